// File: rtl/sdram_dq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_dq_pkg
// Purpose  : Shared constants, encodings, typedefs and helpers for the SDRAM
//            data path and the command FSM that drives it.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_dq_pkg;

  // Supported CAS latencies (clk cycles)
  localparam int unsigned c_CL2 = 2;
  localparam int unsigned c_CL3 = 3;

  // Mode-register burst-length field encodings, shared with the command FSM
  localparam logic [2:0] c_BL_ENC_1    = 3'b000;
  localparam logic [2:0] c_BL_ENC_2    = 3'b001;
  localparam logic [2:0] c_BL_ENC_4    = 3'b010;
  localparam logic [2:0] c_BL_ENC_8    = 3'b011;
  localparam logic [2:0] c_BL_ENC_PAGE = 3'b111;

  // Data and mask types at the default DQ width
  localparam int unsigned c_DEFAULT_DATA_W = 16;
  typedef logic [c_DEFAULT_DATA_W-1:0]   dq_data_t;
  typedef logic [c_DEFAULT_DATA_W/8-1:0] dq_mask_t;

  // Ceiling log2, usable in constant expressions
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sdram_rd_pipe
// Purpose  : Read capture-slot shift register. Each READ command ORs a block
//            of BURST_LEN slots, CAS_LAT positions deep, into the pipe; bit 0
//            is the capture strobe for the coming clk edge.
// Ports    : clk, rst_n (async, active-low)
//            i_rd_issue  - READ accepted this edge
//            i_truncate  - BURST TERMINATE this edge
//            o_capture   - sample DQ at the next edge
//            o_pipe_busy - any slot pending
// Revision : 1.0 - initial release
// ============================================================================
module sdram_rd_pipe
  import sdram_dq_pkg::*;
#(
  parameter int unsigned CAS_LAT   = c_CL3,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rd_issue,
  input  logic i_truncate,
  output logic o_capture,
  output logic o_pipe_busy
);

  localparam int unsigned c_PIPE_LEN = CAS_LAT + BURST_LEN;

  // Slot p after an edge means "capture at the p+1-th following edge", so a
  // READ at E0 lands its beats at E(CAS_LAT+1)..E(CAS_LAT+BURST_LEN).
  localparam logic [c_PIPE_LEN-1:0] c_ISSUE_MASK =
    {{BURST_LEN{1'b1}}, {CAS_LAT{1'b0}}};

  // Beats already launched by the SDRAM still return after a terminate:
  // only the nearest CAS_LAT-1 slots survive.
  localparam logic [c_PIPE_LEN-1:0] c_KEEP_MASK =
    c_PIPE_LEN'((64'd1 << (CAS_LAT - 1)) - 64'd1);

  logic [c_PIPE_LEN-1:0] r_slot;
  logic [c_PIPE_LEN-1:0] w_next;

  always_comb begin
    w_next = r_slot >> 1;
    if (i_truncate) w_next = w_next & c_KEEP_MASK;
    if (i_rd_issue) w_next = w_next | c_ISSUE_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_slot <= '0;
    else        r_slot <= w_next;
  end

  assign o_capture   = r_slot[0];
  assign o_pipe_busy = |r_slot;

endmodule
`default_nettype wire

// File: rtl/sdram_dq_path.sv
`default_nettype none
// ============================================================================
// Module   : sdram_dq_path
// Purpose  : SDRAM DQ engine with command-triggered burst timing. Drives write
//            bursts with a data-request handshake and captures read bursts
//            after CAS_LAT with a valid strobe; overlapping reads merge.
// Ports    : clk, rst_n (async, active-low)
//            cmd_write/cmd_read/burst_stop - pulses from the command FSM
//            wr_data/wr_mask/wr_data_req   - user write side
//            rd_data/rd_valid              - user read side
//            busy, err_collide (sticky)    - status
//            sdram_dqm, sdram_dq           - SDRAM pins
// Options  : SDRAM_DQM_EN - drive wr_mask on sdram_dqm during write beats;
//            when undefined sdram_dqm is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_dq_path
  import sdram_dq_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned CAS_LAT   = c_CL3,
  parameter int unsigned DQM_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_write,
  input  logic              cmd_read,
  input  logic              burst_stop,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DQM_W-1:0]  wr_mask,
  output logic              wr_data_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              err_collide,
  output logic [DQM_W-1:0]  sdram_dqm,
  inout  wire  [DATA_W-1:0] sdram_dq
);

  typedef logic [DATA_W-1:0] data_t;

  localparam int unsigned          c_CNT_W   = clog2(BURST_LEN) + 1;
  localparam logic [c_CNT_W-1:0]   c_BL_LOAD = c_CNT_W'(BURST_LEN);
  localparam logic [c_CNT_W-1:0]   c_CNT_ONE = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_wr_cnt;
  logic               r_oe;
  data_t              r_dq_out;
  data_t              r_rd_data;
  logic               r_rd_valid;
  logic               r_err;

  logic w_wr_window;
  logic w_rd_issue;
  logic w_capture;
  logic w_pipe_busy;

  // Remaining beats to request; nonzero means the write window is open.
  assign w_wr_window = (r_wr_cnt != '0);
  // A simultaneous WRITE owns the bus, so the READ is dropped.
  assign w_rd_issue  = cmd_read & ~cmd_write;

  sdram_rd_pipe #(
    .CAS_LAT   (CAS_LAT),
    .BURST_LEN (BURST_LEN)
  ) u_rd_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_issue  (w_rd_issue),
    .i_truncate  (burst_stop),
    .o_capture   (w_capture),
    .o_pipe_busy (w_pipe_busy)
  );

  // Write side: a reload on cmd_write restarts the burst without a Z gap
  // because the output enable simply follows the window one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_oe     <= 1'b0;
      r_dq_out <= '0;
    end else begin
      if (cmd_write)        r_wr_cnt <= c_BL_LOAD;
      else if (burst_stop)  r_wr_cnt <= '0;
      else if (w_wr_window) r_wr_cnt <= r_wr_cnt - c_CNT_ONE;
      r_oe <= w_wr_window;
      if (w_wr_window) r_dq_out <= wr_data;
    end
  end

  // Read side and collision monitor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= w_capture;
      if (w_capture) r_rd_data <= sdram_dq;
      if ((cmd_read && cmd_write) || (w_capture && r_oe)) r_err <= 1'b1;
    end
  end

`ifdef SDRAM_DQM_EN
  logic [DQM_W-1:0] r_dqm;

  // Registered with the beat so it lines up with the DQ output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dqm <= '0;
    else        r_dqm <= w_wr_window ? wr_mask : '0;
  end

  assign sdram_dqm = r_dqm;
`else
  logic w_unused_mask;
  assign w_unused_mask = ^wr_mask;
  assign sdram_dqm     = '0;
`endif

  assign sdram_dq    = r_oe ? r_dq_out : {DATA_W{1'bz}};
  assign wr_data_req = w_wr_window;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign busy        = w_wr_window | r_oe | w_pipe_busy;
  assign err_collide = r_err;

endmodule
`default_nettype wire
